// File: rtl/pret_pkg.sv
// Shared definitions for the multi-output progressive-precision SC engine:
// run states, derived-width helpers and the enumeration bit-reverse.
package pret_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int BR_MAX = 64;

    function automatic int calc_tw(input int w, input int n, input int nc, input int corr);
        return (corr != 0) ? (w + nc) : (w * n + nc);
    endfunction

    function automatic int calc_lw(input int tw);
        return $clog2(tw + 1);
    endfunction

    // Reverses the low 'width' bits of v; bits above 'width' come back zero.
    function automatic logic [63:0] bitrev(input logic [63:0] v, input int width);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < BR_MAX; i++) begin
            if (i < width) begin
                r[width-1-i] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pret_sng.sv
// Stream generator: maps the enumeration counter through a bit-reverse onto
// per-input comparator fields and select bits.
module pret_sng
    import pret_pkg::*;
#(
    parameter int W    = 6,
    parameter int N    = 2,
    parameter int NC   = 1,
    parameter int CORR = 0,
    localparam int TW  = calc_tw(W, N, NC, CORR)
) (
    input  logic            en,
    input  logic [TW-1:0]   cnt,
    input  logic [N*W-1:0]  bx,
    output logic [N-1:0]    xs,
    output logic [NC-1:0]   xcs
);

    logic [TW-1:0] r;

    assign r = TW'(bitrev(64'(cnt), TW));

    for (genvar gi = 0; gi < N; gi++) begin : g_data
        logic [W-1:0] field;
        if (CORR != 0) begin : g_corr
            assign field = r[W-1:0];
        end else begin : g_indep
            assign field = r[(N-1-gi)*W +: W];
        end
        assign xs[gi] = en & (bx[gi*W +: W] > field);
    end

    // Select streams take the most significant reversed bits, so each is an exact 0.5.
    for (genvar gi = 0; gi < NC; gi++) begin : g_sel
        assign xcs[gi] = en & r[TW-1-gi];
    end

endmodule

// File: rtl/pret_mc.sv
// Runtime-length SC engine: latches binary inputs, enumerates 2^L stream
// cycles, accumulates M returned streams and reports full-scale counts.
module pret_mc
    import pret_pkg::*;
#(
    parameter int W    = 6,
    parameter int N    = 2,
    parameter int NC   = 1,
    parameter int M    = 1,
    parameter int CORR = 0,
    localparam int TW  = calc_tw(W, N, NC, CORR),
    localparam int LW  = calc_lw(TW)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LW-1:0]        len,
    input  logic [N*W-1:0]       Bxs,
    output logic [N-1:0]         Xs,
    output logic [NC-1:0]        Xcs,
    input  logic [M-1:0]         Zs,
    output logic [M*(TW+1)-1:0]  Bzs,
    output logic                 busy,
    output logic                 done
);

    localparam logic [LW-1:0] TW_L = LW'(TW);
    localparam logic [TW-1:0] ONES = '1;

    logic [0:0]     state_reg;
    logic [TW-1:0]  cnt_reg;
    logic [LW-1:0]  len_reg;
    logic [N*W-1:0] bx_reg;
    logic           done_reg;

    logic [LW-1:0]  len_clamped;
    logic [LW-1:0]  shift_amt;
    logic [TW-1:0]  last_cnt;
    logic           is_last;

    assign len_clamped = (len > TW_L) ? TW_L : len;
    assign shift_amt   = TW_L - len_reg;
    assign last_cnt    = ONES >> shift_amt;
    assign busy        = (state_reg == ST_RUN);
    assign is_last     = busy && (cnt_reg == last_cnt);
    assign done        = done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            len_reg   <= '0;
            bx_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_RUN;
                        cnt_reg   <= '0;
                        len_reg   <= len_clamped;
                        bx_reg    <= Bxs;
                    end
                end
                default: begin
                    if (is_last) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + TW'(1);
                    end
                end
            endcase
        end
    end

    pret_sng #(
        .W    (W),
        .N    (N),
        .NC   (NC),
        .CORR (CORR)
    ) u_sng (
        .en  (busy),
        .cnt (cnt_reg),
        .bx  (bx_reg),
        .xs  (Xs),
        .xcs (Xcs)
    );

    for (genvar gi = 0; gi < M; gi++) begin : g_acc
        logic [TW:0] acc_reg;
        logic [TW:0] bz_reg;
        logic [TW:0] acc_next;

        assign acc_next = acc_reg + (TW+1)'(Zs[gi]);

        // The final cycle's Zs is folded in on the way to the result register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_reg <= '0;
                bz_reg  <= '0;
            end else if (busy) begin
                if (is_last) begin
                    acc_reg <= '0;
                    bz_reg  <= acc_next << shift_amt;
                end else begin
                    acc_reg <= acc_next;
                end
            end
        end

        assign Bzs[gi*(TW+1) +: TW+1] = bz_reg;
    end

endmodule

// File: tb/tb_pret_mc.sv
// Directed bench for pret_mc: three configurations (independent, correlated,
// two-output) driven with hand-computed vectors.
module tb_pret_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  start_s;
    logic [3:0]  len_s;
    logic [11:0] bxs;
    logic        z_or;

    logic [1:0]  xs_a, xs_b, xs_c;
    logic [0:0]  xcs_a, xcs_b, xcs_c;
    logic        za, zb;
    logic [1:0]  zc;
    logic [13:0] bzs_a;
    logic [7:0]  bzs_b;
    logic [27:0] bzs_c;
    logic [2:0]  busy_s, done_s;

    // Application circuits: mux, AND/OR, and a two-output pair.
    assign za = xcs_a[0] ? xs_a[0] : xs_a[1];
    assign zb = z_or ? (xs_b[0] | xs_b[1]) : (xs_b[0] & xs_b[1]);
    assign zc = {xcs_c[0], xs_c[0] & xs_c[1]};

    pret_mc #(.W(6), .N(2), .NC(1), .M(1), .CORR(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .len(len_s), .Bxs(bxs),
        .Xs(xs_a), .Xcs(xcs_a), .Zs(za), .Bzs(bzs_a), .busy(busy_s[0]), .done(done_s[0])
    );

    pret_mc #(.W(6), .N(2), .NC(1), .M(1), .CORR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .len(len_s[2:0]), .Bxs(bxs),
        .Xs(xs_b), .Xcs(xcs_b), .Zs(zb), .Bzs(bzs_b), .busy(busy_s[1]), .done(done_s[1])
    );

    pret_mc #(.W(6), .N(2), .NC(1), .M(2), .CORR(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .len(len_s), .Bxs(bxs),
        .Xs(xs_c), .Xcs(xcs_c), .Zs(zc), .Bzs(bzs_c), .busy(busy_s[2]), .done(done_s[2])
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] read_bzs(input int sel, input int ch);
        case (sel)
            0:       return 64'(bzs_a);
            1:       return 64'(bzs_b);
            default: return (ch != 0) ? 64'(bzs_c[27:14]) : 64'(bzs_c[13:0]);
        endcase
    endfunction

    function automatic logic [63:0] read_xs(input int sel);
        case (sel)
            0:       return 64'({xcs_a, xs_a});
            1:       return 64'({xcs_b, xs_b});
            default: return 64'({xcs_c, xs_c});
        endcase
    endfunction

    task automatic run(input int sel, input int ln, input int bx0, input int bx1,
                       input bit inject, output int cycles, output int dones);
        @(negedge clk);
        len_s        = ln[3:0];
        bxs          = {bx1[5:0], bx0[5:0]};
        start_s[sel] = 1'b1;
        @(negedge clk);
        start_s[sel] = 1'b0;
        cycles = 0;
        dones  = 0;
        for (int k = 0; k < 10000; k++) begin
            if (busy_s[sel]) cycles++;
            start_s[sel] = (inject && cycles == 5);
            if (done_s[sel]) begin
                dones++;
                break;
            end
            @(negedge clk);
        end
        start_s[sel] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done_s[sel]) dones++;
        end
    endtask

    task automatic expect_run(input string tag, input int sel, input int ln, input int bx0,
                              input int bx1, input bit inject, input int exp_cycles,
                              input int exp0, input int exp1);
        int cycles, dones;
        run(sel, ln, bx0, bx1, inject, cycles, dones);
        $display("run %s: dut=%0d len=%0d bx={%0d,%0d} cycles=%0d dones=%0d bzs0=%0d bzs1=%0d",
                 tag, sel, ln, bx0, bx1, cycles, dones, read_bzs(sel, 0), read_bzs(sel, 1));
        check({tag, ".cycles"}, 64'(cycles), 64'(exp_cycles));
        check({tag, ".dones"}, 64'(dones), 64'd1);
        check({tag, ".bzs0"}, read_bzs(sel, 0), 64'(exp0));
        if (sel == 2) check({tag, ".bzs1"}, read_bzs(sel, 1), 64'(exp1));
        check({tag, ".busy_idle"}, 64'(busy_s[sel]), 64'd0);
        check({tag, ".xs_idle"}, read_xs(sel), 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_s = '0;
        len_s   = '0;
        bxs     = '0;
        z_or    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.busy", 64'(busy_s), 64'd0);
        check("rst.done", 64'(done_s), 64'd0);
        check("rst.bzs_a", 64'(bzs_a), 64'd0);
        check("rst.bzs_c", 64'(bzs_c), 64'd0);
        check("rst.xs_a", read_xs(0), 64'd0);
        rst_n = 1'b1;

        expect_run("a_len13",  0, 13, 48, 16, 1'b0, 8192, 4096, 0);
        expect_run("a_len3",   0,  3, 48, 16, 1'b0,    8, 7168, 0);
        expect_run("a_len1",   0,  1, 48, 16, 1'b0,    2, 8192, 0);
        expect_run("a_len0",   0,  0, 48, 16, 1'b0,    1, 8192, 0);
        expect_run("a_bx0",    0,  3,  0,  0, 1'b0,    8,    0, 0);
        expect_run("a_len15",  0, 15, 48, 16, 1'b1, 8192, 4096, 0);

        z_or = 1'b0;
        expect_run("b_and",    1,  7, 48, 16, 1'b0,  128,   32, 0);
        z_or = 1'b1;
        expect_run("b_or",     1,  7, 48, 16, 1'b0,  128,   96, 0);

        expect_run("c_m2",     2, 13, 48, 16, 1'b0, 8192, 1536, 4096);

        // Abort a run at cnt=100 with reset; the previous result must be held until then.
        @(negedge clk);
        len_s      = 4'd13;
        bxs        = {6'd16, 6'd48};
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (100) @(negedge clk);
        check("abort.busy_before", 64'(busy_s[0]), 64'd1);
        check("abort.bzs_held", 64'(bzs_a), 64'd4096);
        rst_n = 1'b0;
        #1;
        $display("abort: busy=%0d done=%0d bzs=%0d", busy_s[0], done_s[0], bzs_a);
        check("abort.busy", 64'(busy_s[0]), 64'd0);
        check("abort.done", 64'(done_s[0]), 64'd0);
        check("abort.bzs", 64'(bzs_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        expect_run("a_after_abort", 0, 2, 48, 16, 1'b0, 4, 8192, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
